// File: rtl/mc_ctrl_fsm_pkg.sv
// ctrl_pkg: encodings shared by the multi-cycle control sequencer and the
// datapath muxes it steers.
//   state_e   : sequencer states (3 bits, also exported on state_o)
//   pc_sel_e  : PC source mux select
//   wb_sel_e  : register-file writeback mux select
//   F_*       : bit positions of the decoder class flags when packed as
//               {r_type,load,i_type,jalr,s_type,sb_type,u_type,uj_type,auipc}
//   class_ok(): true when the packed flags name exactly one class
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      FWAIT  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      MWAIT  = 3'd5,
      TRAP   = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_BR    = 2'd1,
      PC_JAL   = 2'd2,
      PC_JALR  = 2'd3
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   localparam int unsigned F_R     = 8;
   localparam int unsigned F_LOAD  = 7;
   localparam int unsigned F_I     = 6;
   localparam int unsigned F_JALR  = 5;
   localparam int unsigned F_S     = 4;
   localparam int unsigned F_SB    = 3;
   localparam int unsigned F_U     = 2;
   localparam int unsigned F_UJ    = 1;
   localparam int unsigned F_AUIPC = 0;

   // AUIPC is reported by the decoder as u_type plus auipc, so that one
   // two-flag combination is still a single class.
   function automatic logic class_ok(input logic [8:0] f);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (f[i]) n++;
      end
      return (n == 1) || (n == 2 && f[F_U] && f[F_AUIPC]);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: instruction- and data-memory request/grant/response
// handshake between the control sequencer and the memory side.
//   imem_req/imem_gnt/imem_rvalid : fetch request, accept, word valid
//   dmem_req/dmem_gnt/dmem_rvalid : data request, accept, load data/store ack
//   dmem_we                       : data request is a store
// Modports: master = sequencer, slave = memory.
interface mc_ctrl_fsm_if;

   logic imem_req;
   logic imem_gnt;
   logic imem_rvalid;
   logic dmem_req;
   logic dmem_gnt;
   logic dmem_rvalid;
   logic dmem_we;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
   );

endinterface

// File: rtl/mc_ctrl_fsm_wdog.sv
// mem_wdog: memory-wait watchdog. Saturating counter that is cleared on
// every sequencer state change and counts while an awaited handshake is low.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : sequencer leaves its current state this cycle
//   en         : the awaited gnt/rvalid is low this cycle
//   tmo        : this waiting cycle is the TMO_CYC-th one; the sequencer
//                traps at the edge that would bring the count to TMO_CYC
module mem_wdog #(
   parameter int unsigned TMO_W   = 8,
   parameter int unsigned TMO_CYC = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tmo
);

   logic [TMO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tmo = en && (cnt >= TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the RV32I core, one
// instruction in flight: FETCH -> FWAIT -> DECODE -> EXEC | MEM -> MWAIT.
// Unknown/ambiguous class flags or a memory-wait timeout park it in TRAP
// until rst_n.
//   clk, rst_n         : core clock, asynchronous active-low reset
//   r_type..auipc      : decoder class flags (valid from DECODE, held by IR)
//   br_taken           : branch comparator result (valid in EXEC)
//   mem                : imem/dmem handshake (master side)
//   ir_we, pc_we, rf_we: IR latch, PC update, regfile write strobes
//   pc_sel, wb_sel     : PC source and writeback source (ctrl_pkg encodings)
//   trap               : sticky fault flag
//   state_o            : current state for debug
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned TMO_W   = 8,
   parameter int unsigned TMO_CYC = 200
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                r_type,
   input  logic                load,
   input  logic                i_type,
   input  logic                jalr,
   input  logic                s_type,
   input  logic                sb_type,
   input  logic                u_type,
   input  logic                uj_type,
   input  logic                auipc,
   input  logic                br_taken,
   mc_ctrl_fsm_if.master       mem,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic                trap,
   output logic [2:0]          state_o
);

   state_e     state;
   logic [8:0] flags;
   logic       wd_en;
   logic       wd_tmo;
   logic       leave;

   assign flags = {r_type, load, i_type, jalr, s_type, sb_type, u_type, uj_type, auipc};

   // Watchdog counts only while the awaited handshake of a wait state is low.
   always_comb begin
      wd_en = 1'b0;
      case (state)
         FETCH:   wd_en = !mem.imem_gnt;
         FWAIT:   wd_en = !mem.imem_rvalid;
         MEM:     wd_en = !mem.dmem_gnt;
         MWAIT:   wd_en = !mem.dmem_rvalid;
         default: wd_en = 1'b0;
      endcase
   end

   // Any state change clears the watchdog, so each wait starts from zero.
   always_comb begin
      leave = 1'b0;
      case (state)
         FETCH:   leave = mem.imem_gnt;
         FWAIT:   leave = mem.imem_rvalid;
         DECODE:  leave = 1'b1;
         EXEC:    leave = 1'b1;
         MEM:     leave = mem.dmem_gnt;
         MWAIT:   leave = mem.dmem_rvalid;
         default: leave = 1'b0;
      endcase
      if (wd_tmo) leave = 1'b1;
   end

   mem_wdog #(
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
   ) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (leave),
      .en    (wd_en),
      .tmo   (wd_tmo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:  if (wd_tmo) state <= TRAP; else if (mem.imem_gnt) state <= FWAIT;
            FWAIT:  if (wd_tmo) state <= TRAP; else if (mem.imem_rvalid) state <= DECODE;
            DECODE: begin
               if (!class_ok(flags))      state <= TRAP;
               else if (load || s_type)   state <= MEM;
               else                       state <= EXEC;
            end
            EXEC:   state <= FETCH;
            MEM:    if (wd_tmo) state <= TRAP; else if (mem.dmem_gnt) state <= MWAIT;
            MWAIT:  if (wd_tmo) state <= TRAP; else if (mem.dmem_rvalid) state <= FETCH;
            TRAP:   state <= TRAP;
            default: state <= TRAP;
         endcase
      end
   end

   // Strobes are decoded from the registered state; ir_we and the MWAIT
   // writes also qualify on rvalid. Requests stay up through the gnt cycle
   // and fall at the edge that samples gnt. Gating with rst_n keeps every
   // output low while reset is held, including imem_req in FETCH.
   always_comb begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
      trap         = 1'b0;
      if (rst_n) begin
         case (state)
            FETCH: mem.imem_req = 1'b1;
            FWAIT: ir_we = mem.imem_rvalid;
            EXEC: begin
               pc_we = 1'b1;
               if (jalr) begin
                  rf_we  = 1'b1;
                  wb_sel = WB_PC4;
                  pc_sel = PC_JALR;
               end else if (uj_type) begin
                  rf_we  = 1'b1;
                  wb_sel = WB_PC4;
                  pc_sel = PC_JAL;
               end else if (sb_type) begin
                  pc_sel = br_taken ? PC_BR : PC_PLUS4;
               end else if (u_type || auipc) begin
                  rf_we  = 1'b1;
                  wb_sel = auipc ? WB_ALU : WB_IMM;
               end else begin
                  rf_we  = 1'b1;
               end
            end
            MEM: begin
               mem.dmem_req = 1'b1;
               mem.dmem_we  = s_type;
            end
            MWAIT: begin
               if (mem.dmem_rvalid) begin
                  pc_we = 1'b1;
                  rf_we = load;
                  if (load) wb_sel = WB_MEM;
               end
            end
            TRAP: trap = 1'b1;
            default: ;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
   import ctrl_pkg::*;

   localparam logic [8:0] FL_R     = 9'b1_0000_0000;
   localparam logic [8:0] FL_LOAD  = 9'b0_1000_0000;
   localparam logic [8:0] FL_I     = 9'b0_0100_0000;
   localparam logic [8:0] FL_JALR  = 9'b0_0010_0000;
   localparam logic [8:0] FL_S     = 9'b0_0001_0000;
   localparam logic [8:0] FL_SB    = 9'b0_0000_1000;
   localparam logic [8:0] FL_U     = 9'b0_0000_0100;
   localparam logic [8:0] FL_UJ    = 9'b0_0000_0010;
   localparam logic [8:0] FL_AUIPC = 9'b0_0000_0001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] fl = '0;
   logic       br = 1'b0;
   logic       ir_we, pc_we, rf_we, trap;
   logic [1:0] pc_sel, wb_sel;
   logic [2:0] state_o;

   mc_ctrl_fsm_if mif();

   mc_ctrl_fsm #(.TMO_W(8), .TMO_CYC(200)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .r_type   (fl[8]),
      .load     (fl[7]),
      .i_type   (fl[6]),
      .jalr     (fl[5]),
      .s_type   (fl[4]),
      .sb_type  (fl[3]),
      .u_type   (fl[2]),
      .uj_type  (fl[1]),
      .auipc    (fl[0]),
      .br_taken (br),
      .mem      (mif),
      .ir_we    (ir_we),
      .pc_we    (pc_we),
      .pc_sel   (pc_sel),
      .rf_we    (rf_we),
      .wb_sel   (wb_sel),
      .trap     (trap),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [8:0] fl;
      logic       br;
      logic       trp;
      logic       mem;
      logic       st;
      logic       rf;
      logic [1:0] wb;
      logic [1:0] pc;
   } vec_t;

   vec_t vecs[13];
   int   nerr = 0;
   int   nchk = 0;
   int   pc_cnt = 0;
   int   rf_cnt = 0;

   function automatic vec_t mk(string nm, logic [8:0] f, logic b, logic t, logic m,
                               logic s, logic r, logic [1:0] w, logic [1:0] p);
      vec_t v;
      v.nm = nm; v.fl = f; v.br = b; v.trp = t; v.mem = m;
      v.st = s; v.rf = r; v.wb = w; v.pc = p;
      return v;
   endfunction

   function automatic logic [10:0] outs();
      return {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_we, pc_we, pc_sel,
              rf_we, wb_sel, trap};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_st(input string nm, input state_e exp);
      chk(nm, 32'(state_o), 32'(exp));
   endtask

   task automatic samp();
      @(negedge clk);
      pc_cnt += int'(pc_we);
      rf_cnt += int'(rf_we);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fl = '0; br = 1'b0;
      mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0;
      mif.dmem_gnt = 1'b0; mif.dmem_rvalid = 1'b0;
   endtask

   // Returns at posedge+1 with rst_n just released, DUT in FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      samp();
      chk("reset_outs", 32'(outs()), 32'd0);
      chk_st("reset_state", FETCH);
      adv();
      rst_n = 1'b1;
   endtask

   // Immediate gnt/rvalid fetch, ending at posedge+1 after the DECODE cycle.
   task automatic fetch_decode(input logic [8:0] f, input logic b);
      fl = f; br = b;
      pc_cnt = 0; rf_cnt = 0;
      mif.imem_gnt = 1'b1; mif.imem_rvalid = 1'b1;
      samp();
      chk_st("fetch_state", FETCH);
      chk("fetch_req", 32'(mif.imem_req), 32'd1);
      chk("fetch_ir_we", 32'(ir_we), 32'd0);
      adv();
      samp();
      chk_st("fwait_state", FWAIT);
      chk("fwait_ir_we", 32'(ir_we), 32'd1);
      chk("fwait_req", 32'(mif.imem_req), 32'd0);
      adv();
      mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0;
      samp();
      chk_st("decode_state", DECODE);
      adv();
   endtask

   task automatic run_vec(input vec_t v);
      fetch_decode(v.fl, v.br);
      samp();
      if (v.trp) begin
         chk_st({v.nm, "_trap_state"}, TRAP);
         chk({v.nm, "_trap"}, 32'(trap), 32'd1);
         chk({v.nm, "_trap_req"}, 32'(mif.imem_req), 32'd0);
         chk({v.nm, "_trap_pcwe"}, 32'(pc_cnt), 32'd0);
         do_reset();
      end else begin
         if (!v.mem) begin
            chk_st({v.nm, "_exec_state"}, EXEC);
            chk({v.nm, "_rf_we"}, 32'(rf_we), 32'(v.rf));
            if (v.rf) chk({v.nm, "_wb_sel"}, 32'(wb_sel), 32'(v.wb));
            chk({v.nm, "_pc_sel"}, 32'(pc_sel), 32'(v.pc));
            adv();
         end else begin
            chk_st({v.nm, "_mem_state"}, MEM);
            chk({v.nm, "_dmem_req"}, 32'(mif.dmem_req), 32'd1);
            chk({v.nm, "_dmem_we"}, 32'(mif.dmem_we), 32'(v.st));
            adv();
            mif.dmem_gnt = 1'b1;
            samp();
            adv();
            mif.dmem_gnt = 1'b0; mif.dmem_rvalid = 1'b1;
            samp();
            chk_st({v.nm, "_mwait_state"}, MWAIT);
            chk({v.nm, "_rf_we"}, 32'(rf_we), 32'(v.rf));
            if (v.rf) chk({v.nm, "_wb_sel"}, 32'(wb_sel), 32'(v.wb));
            chk({v.nm, "_pc_sel"}, 32'(pc_sel), 32'(v.pc));
            adv();
            mif.dmem_rvalid = 1'b0;
         end
         samp();
         chk_st({v.nm, "_back_fetch"}, FETCH);
         chk({v.nm, "_pc_we_pulses"}, 32'(pc_cnt), 32'd1);
         chk({v.nm, "_rf_we_pulses"}, 32'(rf_cnt), 32'(v.rf));
         adv();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vecs[0]  = mk("ADD",   FL_R,              1'b0, 0, 0, 0, 1, 2'd0, 2'd0);
      vecs[1]  = mk("ADDI",  FL_I,              1'b0, 0, 0, 0, 1, 2'd0, 2'd0);
      vecs[2]  = mk("LW",    FL_LOAD,           1'b0, 0, 1, 0, 1, 2'd1, 2'd0);
      vecs[3]  = mk("SW",    FL_S,              1'b0, 0, 1, 1, 0, 2'd0, 2'd0);
      vecs[4]  = mk("BEQT",  FL_SB,             1'b1, 0, 0, 0, 0, 2'd0, 2'd1);
      vecs[5]  = mk("BEQN",  FL_SB,             1'b0, 0, 0, 0, 0, 2'd0, 2'd0);
      vecs[6]  = mk("JAL",   FL_UJ,             1'b0, 0, 0, 0, 1, 2'd2, 2'd2);
      vecs[7]  = mk("JALR",  FL_JALR,           1'b0, 0, 0, 0, 1, 2'd2, 2'd3);
      vecs[8]  = mk("LUI",   FL_U,              1'b0, 0, 0, 0, 1, 2'd3, 2'd0);
      vecs[9]  = mk("AUIPC", FL_U | FL_AUIPC,   1'b0, 0, 0, 0, 1, 2'd0, 2'd0);
      vecs[10] = mk("NONE",  9'd0,              1'b0, 1, 0, 0, 0, 2'd0, 2'd0);
      vecs[11] = mk("RLOAD", FL_R | FL_LOAD,    1'b0, 1, 0, 0, 0, 2'd0, 2'd0);
      vecs[12] = mk("JRAUI", FL_JALR | FL_AUIPC,1'b0, 1, 0, 0, 0, 2'd0, 2'd0);

      do_reset();
      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // LW: dmem_gnt in the 4th MEM cycle, rvalid two cycles after gnt.
      fetch_decode(FL_LOAD, 1'b0);
      n = 0;
      for (int c = 0; c < 4; c++) begin
         mif.dmem_gnt = (c == 3);
         samp();
         n += int'(mif.dmem_req);
         chk("lwd_dmem_we", 32'(mif.dmem_we), 32'd0);
         adv();
      end
      mif.dmem_gnt = 1'b0;
      chk("lwd_req_cycles", 32'(n), 32'd4);
      samp();
      chk_st("lwd_mwait", MWAIT);
      chk("lwd_req_dropped", 32'(mif.dmem_req), 32'd0);
      chk("lwd_early_rf_we", 32'(rf_we), 32'd0);
      adv();
      mif.dmem_rvalid = 1'b1;
      samp();
      chk("lwd_rf_we", 32'(rf_we), 32'd1);
      chk("lwd_wb_sel", 32'(wb_sel), 32'd1);
      chk("lwd_pc_we", 32'(pc_we), 32'd1);
      adv();
      mif.dmem_rvalid = 1'b0;
      samp();
      chk_st("lwd_fetch", FETCH);
      chk("lwd_pulses", 32'(pc_cnt), 32'd1);
      adv();

      // TRAP is sticky: memory keeps offering gnt/rvalid, no requests appear.
      fetch_decode(9'd0, 1'b0);
      n = 0;
      fl = FL_R;
      mif.imem_gnt = 1'b1; mif.imem_rvalid = 1'b1;
      mif.dmem_gnt = 1'b1; mif.dmem_rvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         samp();
         n += int'(mif.imem_req) + int'(mif.dmem_req) + int'(trap == 1'b0);
         adv();
      end
      chk("trap_sticky", 32'(n), 32'd0);
      chk("trap_no_writes", 32'(pc_cnt + rf_cnt), 32'd0);
      do_reset();
      samp();
      chk("trap_cleared_req", 32'(mif.imem_req), 32'd1);
      chk("trap_cleared_flag", 32'(trap), 32'd0);
      adv();
      do_reset();

      // imem_gnt never arrives: 200 FETCH cycles, then TRAP.
      n = 0;
      for (int c = 0; c < 300; c++) begin
         samp();
         if (state_o == 3'(FETCH) && mif.imem_req) n++;
         else break;
         adv();
      end
      chk("wdog_fetch_cycles", 32'(n), 32'd200);
      chk_st("wdog_trap_state", TRAP);
      chk("wdog_trap", 32'(trap), 32'd1);
      chk("wdog_req_dropped", 32'(mif.imem_req), 32'd0);
      adv();
      do_reset();

      // gnt in the 200th FETCH cycle is still accepted.
      repeat (199) begin samp(); adv(); end
      mif.imem_gnt = 1'b1;
      samp();
      chk_st("wdog_edge_fetch", FETCH);
      adv();
      mif.imem_gnt = 1'b0;
      samp();
      chk_st("wdog_edge_fwait", FWAIT);
      adv();
      do_reset();

      // Reset asserted mid-MWAIT.
      fetch_decode(FL_LOAD, 1'b0);
      mif.dmem_gnt = 1'b1;
      samp();
      adv();
      mif.dmem_gnt = 1'b0;
      samp();
      chk_st("rst_mwait_state", MWAIT);
      adv();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", 32'(outs()), 32'd0);
      chk("rst_mid_state", 32'(state_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fl = '0;
      samp();
      chk_st("rst_release_state", FETCH);
      chk("rst_release_req", 32'(mif.imem_req), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
